// File: rtl/seg_display_scheduler_if.sv
// Display-sharing bus: two requesters' level requests and values in, the grant and board pin drive out.
// Latency: n/a (wires only).
// Backpressure: none; req is a level request and gnt is its acknowledgement.
interface seg_display_scheduler_if;
    logic [1:0] req;
    logic [3:0] data_a;
    logic [3:0] data_b;
    logic [1:0] gnt;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output req, data_a, data_b,
        input  gnt, busy, seg, an, dp
    );

    modport slave (
        input  req, data_a, data_b,
        output gnt, busy, seg, an, dp
    );
endinterface

// File: rtl/seg_display_scheduler.sv
// Shares the 4-digit 7-seg display between requesters A/B: round-robin arbiter with min hold, anode scan, encode.
// Latency: req->gnt 1 cycle; all outputs registered; seg is encoded for the anode that goes live on the same edge.
// Backpressure: level req/gnt only; one dead cycle on every A<->B switch. SCHED_FIXED_PRIO_EN selects fixed A priority.
module seg_display_scheduler #(
    parameter int REFRESH_CNT = 65000,
    parameter int HOLD_FRAMES = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg_display_scheduler_if.slave bus
);

    localparam int RW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_OWN_A = 7'b0001000;
    localparam logic [6:0] SEG_OWN_B = 7'b0000011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    function automatic logic [6:0] f_digit(input logic [4:0] mag);
        logic [6:0] pat;
        case (mag)
            5'd0:    pat = 7'b1000000;
            5'd1:    pat = 7'b1111001;
            5'd2:    pat = 7'b0100100;
            5'd3:    pat = 7'b0110000;
            5'd4:    pat = 7'b0011001;
            5'd5:    pat = 7'b0010010;
            5'd6:    pat = 7'b0000010;
            5'd7:    pat = 7'b1111000;
            5'd8:    pat = 7'b0000000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    state_t        r_state;
    logic          r_owner;
    logic [HW-1:0] r_hold;
    logic [RW-1:0] r_refresh;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic [1:0]    r_gnt;
    logic          r_busy;
`ifndef SCHED_FIXED_PRIO_EN
    logic          r_ptr;
    logic          w_ptr_nxt;
`endif

    state_t        w_state_nxt;
    logic          w_owner_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_roll;
    logic          w_frame;
    logic [3:0]    w_an_nxt;
    logic          w_own_req;
    logic          w_other_req;
    logic          w_preempt;
    logic [1:0]    w_gnt_nxt;
    logic [3:0]    w_val;
    logic [4:0]    w_sext;
    logic [4:0]    w_mag;
    logic [6:0]    w_seg_nxt;

    // Scan timing: a frame boundary is the rollover that leaves the last digit.
    assign w_roll   = (r_refresh == RW'(REFRESH_CNT - 1));
    assign w_frame  = w_roll && (r_an == 4'b0111);
    assign w_an_nxt = w_roll ? {r_an[2:0], r_an[3]} : r_an;

    assign w_own_req   = bus.req[r_owner];
    assign w_other_req = bus.req[~r_owner];
`ifdef SCHED_FIXED_PRIO_EN
    assign w_preempt   = w_other_req && r_owner;
`else
    assign w_preempt   = w_other_req;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold;
`ifndef SCHED_FIXED_PRIO_EN
        w_ptr_nxt   = r_ptr;
`endif
        case (r_state)
            S_IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = S_GRANT;
                    w_hold_nxt  = '0;
                    if (bus.req == 2'b11) begin
`ifdef SCHED_FIXED_PRIO_EN
                        w_owner_nxt = 1'b0;
`else
                        w_owner_nxt = r_ptr;
`endif
                    end else begin
                        w_owner_nxt = bus.req[1];
                    end
                end
            end
            S_GRANT: begin
                if (!w_own_req) begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
`ifndef SCHED_FIXED_PRIO_EN
                    w_ptr_nxt   = ~r_owner;
`endif
                end else if (r_hold == HW'(HOLD_FRAMES)) begin
                    w_hold_nxt = '0;
                    if (w_preempt) begin
                        w_state_nxt = S_SWITCH;
`ifndef SCHED_FIXED_PRIO_EN
                        w_ptr_nxt   = ~r_owner;
`endif
                    end
                end else if (w_frame) begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            S_SWITCH: begin
                w_state_nxt = S_GRANT;
                w_owner_nxt = ~r_owner;
                w_hold_nxt  = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign w_gnt_nxt = (w_state_nxt == S_GRANT) ? (w_owner_nxt ? 2'b10 : 2'b01) : 2'b00;
    assign w_val     = w_owner_nxt ? bus.data_b : bus.data_a;
    assign w_sext    = {w_val[3], w_val};
    assign w_mag     = w_val[3] ? (~w_sext + 5'd1) : w_sext;

    // Encode against the next grant and next anode so seg, an and gnt change together.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        if (w_gnt_nxt != 2'b00) begin
            case (w_an_nxt)
                4'b1110: w_seg_nxt = f_digit(w_mag);
                4'b1101: w_seg_nxt = w_val[3] ? SEG_MINUS : SEG_BLANK;
                4'b0111: w_seg_nxt = w_owner_nxt ? SEG_OWN_B : SEG_OWN_A;
                default: w_seg_nxt = SEG_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_hold    <= '0;
            r_refresh <= '0;
            r_an      <= 4'b1110;
            r_seg     <= SEG_BLANK;
            r_gnt     <= 2'b00;
            r_busy    <= 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
            r_ptr     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_hold    <= w_hold_nxt;
            r_refresh <= w_roll ? '0 : r_refresh + RW'(1);
            r_an      <= w_an_nxt;
            r_seg     <= w_seg_nxt;
            r_gnt     <= w_gnt_nxt;
            r_busy    <= |w_gnt_nxt;
`ifndef SCHED_FIXED_PRIO_EN
            r_ptr     <= w_ptr_nxt;
`endif
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.busy = r_busy;
    assign bus.seg  = r_seg;
    assign bus.an   = r_an;
    assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: directed steps then random req/data against a time-based reference model.
// Latency: n/a. Backpressure: n/a.
// Honours SCHED_FIXED_PRIO_EN in the model and directed expectations.
module tb_seg_display_scheduler;

    localparam int R = 4;
    localparam int H = 2;
    localparam int F = 4 * R;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_display_scheduler_if bus_if ();

    seg_display_scheduler #(.REFRESH_CNT(R), .HOLD_FRAMES(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model state: m_t = clock edges since reset release; m_start = edge index where the hold window began.
    int m_t;
    int m_start;
    bit m_active;
    bit m_dead;
    bit m_owner;
    bit m_ptr;

    logic [6:0] seg_tab [9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_start = 0; m_active = 0; m_dead = 0; m_owner = 0; m_ptr = 0;
    endtask

    // Frame boundaries passed since the hold window began, counted purely from elapsed edges.
    function automatic int held_frames();
        return (m_t / F) - ((m_start + 1) / F);
    endfunction

    task automatic model_step();
        logic [1:0] rq;
        bit oth;
        rq = bus_if.req;
        if (m_dead) begin
            m_owner = !m_owner; m_dead = 0; m_start = m_t;
        end else if (!m_active) begin
            if (rq != 2'b00) begin
                m_active = 1; m_start = m_t;
`ifdef SCHED_FIXED_PRIO_EN
                m_owner = (rq == 2'b11) ? 1'b0 : rq[1];
`else
                m_owner = (rq == 2'b11) ? m_ptr : rq[1];
`endif
            end
        end else if (!rq[m_owner]) begin
            m_active = 0; m_ptr = !m_owner;
        end else if (held_frames() >= H) begin
            oth = rq[!m_owner];
`ifdef SCHED_FIXED_PRIO_EN
            oth = oth && m_owner;
`endif
            if (oth) begin m_dead = 1; m_ptr = !m_owner; end
            m_start = m_t;
        end
        m_t++;
    endtask

    task automatic check_model();
        int d, v, mag;
        logic [3:0] e_an;
        logic [1:0] e_gnt;
        logic [6:0] e_seg;
        d     = (m_t / R) % 4;
        e_an  = 4'b1111 & ~(4'b0001 << d);
        e_gnt = (m_active && !m_dead) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        v     = m_owner ? int'($signed(bus_if.data_b)) : int'($signed(bus_if.data_a));
        mag   = (v < 0) ? -v : v;
        e_seg = 7'b1111111;
        if (e_gnt != 2'b00) begin
            case (d)
                0: e_seg = seg_tab[mag];
                1: e_seg = (v < 0) ? 7'b0111111 : 7'b1111111;
                3: e_seg = m_owner ? 7'b0000011 : 7'b0001000;
                default: e_seg = 7'b1111111;
            endcase
        end
        chk("model_gnt",  32'(bus_if.gnt),  32'(e_gnt));
        chk("model_busy", 32'(bus_if.busy), 32'(e_gnt != 2'b00));
        chk("model_an",   32'(bus_if.an),   32'(e_an));
        chk("model_seg",  32'(bus_if.seg),  32'(e_seg));
        chk("model_dp",   32'(bus_if.dp),   32'd1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    function automatic logic [6:0] digit_a_neg3(input logic [3:0] an);
        case (an)
            4'b1110: return 7'b0110000;
            4'b1101: return 7'b0111111;
            4'b0111: return 7'b0001000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] digit_b_neg8(input logic [3:0] an);
        case (an)
            4'b1110: return 7'b0000000;
            4'b1101: return 7'b0111111;
            4'b0111: return 7'b0000011;
            default: return 7'b1111111;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        bus_if.req = 2'b00; bus_if.data_a = 4'd0; bus_if.data_b = 4'd0;
        model_reset();

        @(negedge clk);
        chk("reset_gnt",  32'(bus_if.gnt),  32'h0);
        chk("reset_busy", 32'(bus_if.busy), 32'h0);
        chk("reset_seg",  32'(bus_if.seg),  32'h7f);
        chk("reset_an",   32'(bus_if.an),   32'he);
        chk("reset_dp",   32'(bus_if.dp),   32'h1);
        rst_n = 1'b1;
        model_reset();

        repeat (20) tick();
        chk("idle_gnt", 32'(bus_if.gnt), 32'h0);

        // Both request from IDLE after reset: A first, then B after the hold via one dead cycle.
        bus_if.req = 2'b11; bus_if.data_a = 4'd5; bus_if.data_b = 4'b1000;
        tick();
        chk("both_first_A", 32'(bus_if.gnt), 32'h1);
        for (int k = 0; k < 60 && bus_if.gnt == 2'b01; k++) tick();
`ifdef SCHED_FIXED_PRIO_EN
        chk("fixed_A_kept", 32'(bus_if.gnt), 32'h1);
`else
        chk("switch_dead", 32'(bus_if.gnt), 32'h0);
        tick();
        chk("switch_B", 32'(bus_if.gnt), 32'h2);
        for (int k = 0; k < F; k++) begin
            tick();
            chk("b_minus8_digit", 32'(bus_if.seg), 32'(digit_b_neg8(bus_if.an)));
        end
`endif

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt",  32'(bus_if.gnt),  32'h0);
        chk("arst_busy", 32'(bus_if.busy), 32'h0);
        chk("arst_an",   32'(bus_if.an),   32'he);
        chk("arst_seg",  32'(bus_if.seg),  32'h7f);
        @(negedge clk);
        bus_if.req = 2'b00;
        rst_n = 1'b1;
        model_reset();
        repeat (3) tick();

        // A alone showing -3.
        bus_if.req = 2'b01; bus_if.data_a = 4'b1101;
        tick();
        chk("a_grant_latency", 32'(bus_if.gnt), 32'h1);
        for (int k = 0; k < F; k++) begin
            tick();
            chk("a_minus3_digit", 32'(bus_if.seg), 32'(digit_a_neg3(bus_if.an)));
        end
        repeat (2) tick();

        // Owner drop mid-frame, then a simultaneous request favours B.
        bus_if.req = 2'b00;
        tick();
        chk("drop_gnt", 32'(bus_if.gnt), 32'h0);
        chk("drop_seg", 32'(bus_if.seg), 32'h7f);
        bus_if.req = 2'b11;
        tick();
`ifdef SCHED_FIXED_PRIO_EN
        chk("rr_after_drop", 32'(bus_if.gnt), 32'h1);
`else
        chk("rr_after_drop", 32'(bus_if.gnt), 32'h2);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) bus_if.req = 2'($urandom_range(0, 3));
            bus_if.data_a = 4'($urandom);
            bus_if.data_b = 4'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
